// File: rtl/input_port_multi_vc.sv
// Multi-VC router input port.
// One circular flit FIFO per virtual channel. Each FIFO entry also stores the route
// that arrived with the flit, so back-to-back packets can share a VC. A per-VC FSM
// (IDLE/VA/SA) walks each packet through VC allocation and switch allocation.
//
// Flit layout (FLIT_W bits): {flit_label[1:0], vc_id[VC_SIZE-1:0], data[DATA_W-1:0]}
//   flit_label: HEAD=0, BODY=1, TAIL=2, HEADTAIL=3
// Port encoding (PORT_W bits): LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   data_i            incoming flit; data_i.vc_id selects the target VC
//   valid_flit_i      data_i valid this cycle
//   out_port_i        route for data_i, stored alongside the flit
//   vc_valid_i        per-VC downstream VC grant
//   vc_new_i          granted downstream VC per input VC (VC_SIZE bits each)
//   read_i            per-VC switch grant, pops the front flit
//   data_o            front flit per VC with vc_id replaced by the downstream VC
//   out_port_o        route of the packet currently owning each VC
//   va_request_o      VC is in VA
//   sa_request_o      VC is in SA with a non-empty FIFO
//   is_empty_o        FIFO empty
//   is_full_o         FIFO full
//   on_off_o          1 = upstream may keep sending to this VC
//   error_o           sticky protocol-violation flag
module input_port_multi_vc #(
  parameter int unsigned VC_NUM         = 2,
  parameter int unsigned BUFFER_SIZE    = 8,
  parameter int unsigned PIPELINE_DEPTH = 5,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned VC_SIZE        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int unsigned PORT_W         = 3,
  parameter int unsigned FLIT_W         = 2 + VC_SIZE + DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FLIT_W-1:0]         data_i,
  input  logic                      valid_flit_i,
  input  logic [PORT_W-1:0]         out_port_i,
  input  logic [VC_NUM-1:0]         vc_valid_i,
  input  logic [VC_NUM*VC_SIZE-1:0] vc_new_i,
  input  logic [VC_NUM-1:0]         read_i,
  output logic [VC_NUM*FLIT_W-1:0]  data_o,
  output logic [VC_NUM*PORT_W-1:0]  out_port_o,
  output logic [VC_NUM-1:0]         va_request_o,
  output logic [VC_NUM-1:0]         sa_request_o,
  output logic [VC_NUM-1:0]         is_empty_o,
  output logic [VC_NUM-1:0]         is_full_o,
  output logic [VC_NUM-1:0]         on_off_o,
  output logic                      error_o
);

  localparam int unsigned PtrW = $clog2(BUFFER_SIZE);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] LblHead     = 2'd0;
  localparam logic [1:0] LblTail     = 2'd2;
  localparam logic [1:0] LblHeadTail = 2'd3;
  localparam logic [PORT_W-1:0] PortLocal = '0;

  typedef enum logic [1:0] {StIdle, StVa, StSa} state_e;

  logic [FLIT_W-1:0]  r_mem      [VC_NUM][BUFFER_SIZE];
  logic [PORT_W-1:0]  r_route    [VC_NUM][BUFFER_SIZE];
  logic [PtrW-1:0]    r_rd_ptr   [VC_NUM];
  logic [PtrW-1:0]    r_wr_ptr   [VC_NUM];
  logic [CntW-1:0]    r_count    [VC_NUM];
  state_e             r_state    [VC_NUM];
  logic [PORT_W-1:0]  r_out_port [VC_NUM];
  logic [VC_SIZE-1:0] r_vc_new   [VC_NUM];
  logic               r_error;

  logic [FLIT_W-1:0]  w_front       [VC_NUM];
  logic [PORT_W-1:0]  w_front_route [VC_NUM];
  logic [VC_NUM-1:0]  w_empty, w_full, w_head, w_tail;
  logic [VC_NUM-1:0]  w_wr_sel, w_push, w_pop, w_sa_pop, w_drop_pop;
  logic               w_err_set;

  always_comb begin
    w_empty      = '0;
    w_full       = '0;
    w_head       = '0;
    w_tail       = '0;
    w_wr_sel     = '0;
    w_push       = '0;
    w_pop        = '0;
    w_sa_pop     = '0;
    w_drop_pop   = '0;
    w_err_set    = 1'b0;
    data_o       = '0;
    out_port_o   = '0;
    va_request_o = '0;
    sa_request_o = '0;
    is_empty_o   = '0;
    is_full_o    = '0;
    on_off_o     = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_front[v]       = r_mem[v][r_rd_ptr[v]];
      w_front_route[v] = r_route[v][r_rd_ptr[v]];
      w_empty[v] = (r_count[v] == '0);
      w_full[v]  = (r_count[v] == CntW'(BUFFER_SIZE));
      w_head[v]  = (w_front[v][FLIT_W-1 -: 2] == LblHead) ||
                   (w_front[v][FLIT_W-1 -: 2] == LblHeadTail);
      w_tail[v]  = (w_front[v][FLIT_W-1 -: 2] == LblTail) ||
                   (w_front[v][FLIT_W-1 -: 2] == LblHeadTail);

      w_sa_pop[v]   = (r_state[v] == StSa) && read_i[v] && !w_empty[v];
      // A non-head flit at the front of an idle VC has no packet to belong to.
      w_drop_pop[v] = (r_state[v] == StIdle) && !w_empty[v] && !w_head[v];
      w_pop[v]      = w_sa_pop[v] || w_drop_pop[v];

      w_wr_sel[v] = valid_flit_i && (data_i[DATA_W +: VC_SIZE] == VC_SIZE'(v));
      // A full FIFO still accepts a write when it pops in the same cycle.
      w_push[v]   = w_wr_sel[v] && (!w_full[v] || w_pop[v]);

      if ((read_i[v] && !w_sa_pop[v]) || w_drop_pop[v] ||
          (w_wr_sel[v] && w_full[v] && !w_pop[v])) begin
        w_err_set = 1'b1;
      end

      data_o[v*FLIT_W +: FLIT_W] = {w_front[v][FLIT_W-1 -: 2], r_vc_new[v],
                                    w_front[v][DATA_W-1:0]};
      out_port_o[v*PORT_W +: PORT_W] = r_out_port[v];
      va_request_o[v] = (r_state[v] == StVa);
      sa_request_o[v] = (r_state[v] == StSa) && !w_empty[v];
      is_empty_o[v]   = w_empty[v];
      is_full_o[v]    = w_full[v];
      // Free space must cover every flit already in flight on the link.
      on_off_o[v]     = (CntW'(BUFFER_SIZE) - r_count[v]) > CntW'(PIPELINE_DEPTH);
    end
  end

  assign error_o = r_error;

  // Storage needs no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_push[v]) begin
        r_mem[v][r_wr_ptr[v]]   <= data_i;
        r_route[v][r_wr_ptr[v]] <= out_port_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        r_rd_ptr[v]   <= '0;
        r_wr_ptr[v]   <= '0;
        r_count[v]    <= '0;
        r_state[v]    <= StIdle;
        r_out_port[v] <= PortLocal;
        r_vc_new[v]   <= '0;
      end
      r_error <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_push[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PtrW'(1);
        if (w_pop[v])  r_rd_ptr[v] <= r_rd_ptr[v] + PtrW'(1);
        case ({w_push[v], w_pop[v]})
          2'b10:   r_count[v] <= r_count[v] + CntW'(1);
          2'b01:   r_count[v] <= r_count[v] - CntW'(1);
          default: r_count[v] <= r_count[v];
        endcase

        case (r_state[v])
          StIdle: begin
            if (!w_empty[v] && w_head[v]) begin
              r_out_port[v] <= w_front_route[v];
              r_state[v]    <= StVa;
            end
          end
          StVa: begin
            if (vc_valid_i[v]) begin
              r_vc_new[v] <= vc_new_i[v*VC_SIZE +: VC_SIZE];
              r_state[v]  <= StSa;
            end
          end
          StSa: begin
            // The next packet's head, if queued, is picked up from IDLE next cycle.
            if (w_sa_pop[v] && w_tail[v]) r_state[v] <= StIdle;
          end
          default: r_state[v] <= StIdle;
        endcase
      end
      if (w_err_set) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_port_multi_vc.sv
module tb_input_port_multi_vc;

  localparam int FLIT_W = 19;
  localparam logic [1:0] HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3;
  localparam logic [2:0] LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, WEST = 3'd3, EAST = 3'd4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FLIT_W-1:0] data_i = '0;
  logic              valid_flit_i = 1'b0;
  logic [2:0]        out_port_i = '0;
  logic [1:0]        vc_valid_i = '0;
  logic [1:0]        vc_new_i = '0;
  logic [1:0]        read_i = '0;
  logic [2*FLIT_W-1:0] data_o;
  logic [5:0]        out_port_o;
  logic [1:0]        va_request_o, sa_request_o, is_empty_o, is_full_o, on_off_o;
  logic              error_o;

  input_port_multi_vc dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_flit_i (valid_flit_i),
    .out_port_i   (out_port_i),
    .vc_valid_i   (vc_valid_i),
    .vc_new_i     (vc_new_i),
    .read_i       (read_i),
    .data_o       (data_o),
    .out_port_o   (out_port_o),
    .va_request_o (va_request_o),
    .sa_request_o (sa_request_o),
    .is_empty_o   (is_empty_o),
    .is_full_o    (is_full_o),
    .on_off_o     (on_off_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Scoreboard per VC: {label, data} of every flit the port should accept.
  logic [17:0] sb [2][$];
  logic        exp_dvc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: optional write, optional per-VC pops checked against the scoreboard.
  task automatic cycle(input bit wr, input int wvc, input logic [1:0] lab,
                       input logic [15:0] dat, input logic [2:0] port,
                       input logic [1:0] rd, input bit drop);
    logic [17:0] e;
    for (int v = 0; v < 2; v++) begin
      if (rd[v]) begin
        chk($sformatf("sa_req%0d", v), 32'(sa_request_o[v]), 32'(1));
        if (sb[v].size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_empty%0d: got pop expected no pop", v);
        end else begin
          e = sb[v].pop_front();
          chk($sformatf("data_o%0d", v), 32'(data_o[v*FLIT_W +: FLIT_W]),
              32'({e[17:16], exp_dvc[v], e[15:0]}));
        end
      end
    end
    valid_flit_i = wr;
    data_i       = {lab, wvc[0], dat};
    out_port_i   = port;
    read_i       = rd;
    tick();
    valid_flit_i = 1'b0;
    read_i       = '0;
    if (wr && !drop) sb[wvc].push_back({lab, dat});
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    vc_valid_i = '0;
    tick();
    tick();
    rst = 1'b0;
    sb[0].delete();
    sb[1].delete();
    exp_dvc[0] = 1'b0;
    exp_dvc[1] = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_empty"}, 32'(is_empty_o), 32'(2'b11));
    chk({tag, "_full"},  32'(is_full_o), 32'(0));
    chk({tag, "_onoff"}, 32'(on_off_o), 32'(2'b11));
    chk({tag, "_va"},    32'(va_request_o), 32'(0));
    chk({tag, "_sa"},    32'(sa_request_o), 32'(0));
    chk({tag, "_err"},   32'(error_o), 32'(0));
    chk({tag, "_port"},  32'(out_port_o), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check_reset("rst0");

    // HEADTAIL on VC1, immediate VA grant to downstream VC 0
    cycle(1, 1, HEADTAIL, 16'hA001, EAST, 2'b00, 0);
    chk("t1_empty1", 32'(is_empty_o[1]), 32'(0));
    chk("t1_va_early", 32'(va_request_o[1]), 32'(0));
    vc_valid_i = 2'b10;
    vc_new_i   = 2'b00;
    exp_dvc[1] = 1'b0;
    tick();
    chk("t1_va", 32'(va_request_o[1]), 32'(1));
    chk("t1_port", 32'(out_port_o[5:3]), 32'(EAST));
    tick();
    vc_valid_i = 2'b00;
    chk("t1_va_once", 32'(va_request_o[1]), 32'(0));
    chk("t1_sa", 32'(sa_request_o[1]), 32'(1));
    cycle(0, 0, BODY, 16'h0, LOCAL, 2'b10, 0);
    chk("t1_empty_after", 32'(is_empty_o[1]), 32'(1));
    chk("t1_idle_sa", 32'(sa_request_o[1]), 32'(0));
    tick();
    chk("t1_idle_va", 32'(va_request_o[1]), 32'(0));

    // 4-flit packet on VC0 followed back-to-back by another head
    vc_valid_i = 2'b01;
    vc_new_i   = 2'b01;
    exp_dvc[0] = 1'b1;
    cycle(1, 0, HEAD, 16'hB000, WEST,  2'b00, 0);
    cycle(1, 0, BODY, 16'hB001, LOCAL, 2'b00, 0);
    cycle(1, 0, BODY, 16'hB002, LOCAL, 2'b00, 0);
    cycle(1, 0, TAIL, 16'hB003, LOCAL, 2'b00, 0);
    cycle(1, 0, HEAD, 16'hB100, NORTH, 2'b00, 0);
    vc_valid_i = 2'b00;
    chk("t2_sa", 32'(sa_request_o[0]), 32'(1));
    chk("t2_port_w", 32'(out_port_o[2:0]), 32'(WEST));
    for (int i = 0; i < 4; i++) cycle(0, 0, BODY, 16'h0, LOCAL, 2'b01, 0);
    chk("t2_idle_va", 32'(va_request_o[0]), 32'(0));
    chk("t2_idle_sa", 32'(sa_request_o[0]), 32'(0));
    chk("t2_not_empty", 32'(is_empty_o[0]), 32'(0));
    tick();
    chk("t2_va2", 32'(va_request_o[0]), 32'(1));
    chk("t2_port_n", 32'(out_port_o[2:0]), 32'(NORTH));
    vc_valid_i = 2'b01;
    vc_new_i   = 2'b00;
    exp_dvc[0] = 1'b0;
    tick();
    vc_valid_i = 2'b00;
    chk("t2_sa2", 32'(sa_request_o[0]), 32'(1));
    cycle(0, 0, BODY, 16'h0, LOCAL, 2'b01, 0);
    cycle(1, 0, TAIL, 16'hB101, LOCAL, 2'b00, 0);
    cycle(0, 0, BODY, 16'h0, LOCAL, 2'b01, 0);
    chk("t2_empty", 32'(is_empty_o[0]), 32'(1));
    chk("t2_end_sa", 32'(sa_request_o[0]), 32'(0));
    chk("t2_end_va", 32'(va_request_o[0]), 32'(0));
    chk("t2_err", 32'(error_o), 32'(0));

    // Fill VC0 without reads
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, (i == 0) ? HEAD : BODY, 16'(16'h0300 + i), LOCAL, 2'b00, 0);
      chk($sformatf("t3_onoff_%0d", i + 1), 32'(on_off_o[0]), 32'((8 - (i + 1)) > 5));
      chk($sformatf("t3_full_%0d", i + 1), 32'(is_full_o[0]), 32'(i == 7));
    end
    cycle(1, 0, BODY, 16'h03EE, LOCAL, 2'b00, 1);
    chk("t3_err_ovf", 32'(error_o), 32'(1));
    chk("t3_full_ovf", 32'(is_full_o[0]), 32'(1));
    vc_valid_i = 2'b01;
    vc_new_i   = 2'b01;
    exp_dvc[0] = 1'b1;
    tick();
    vc_valid_i = 2'b00;
    chk("t3_sa", 32'(sa_request_o[0]), 32'(1));
    cycle(1, 0, TAIL, 16'h03FF, LOCAL, 2'b01, 0);
    chk("t3_full_wr_rd", 32'(is_full_o[0]), 32'(1));
    for (int i = 0; i < 8; i++) cycle(0, 0, BODY, 16'h0, LOCAL, 2'b01, 0);
    chk("t3_drained", 32'(is_empty_o[0]), 32'(1));
    chk("t3_onoff_back", 32'(on_off_o[0]), 32'(1));
    chk("t3_idle_sa", 32'(sa_request_o[0]), 32'(0));

    // Interleaved writes, VA granted to VC1 only
    vc_valid_i = 2'b10;
    vc_new_i   = 2'b10;
    exp_dvc[1] = 1'b1;
    cycle(1, 0, HEAD, 16'h4000, EAST,  2'b00, 0);
    cycle(1, 1, HEAD, 16'h4100, SOUTH, 2'b00, 0);
    cycle(1, 0, BODY, 16'h4001, LOCAL, 2'b00, 0);
    cycle(1, 1, BODY, 16'h4101, LOCAL, 2'b00, 0);
    cycle(1, 0, TAIL, 16'h4002, LOCAL, 2'b00, 0);
    cycle(1, 1, TAIL, 16'h4102, LOCAL, 2'b00, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, BODY, 16'h0, LOCAL, 2'b10, 0);
    vc_valid_i = 2'b00;
    chk("t4_v1_empty", 32'(is_empty_o[1]), 32'(1));
    chk("t4_v1_idle", 32'({va_request_o[1], sa_request_o[1]}), 32'(0));
    chk("t4_v1_port", 32'(out_port_o[5:3]), 32'(SOUTH));
    tick();
    chk("t4_v0_va", 32'(va_request_o[0]), 32'(1));
    chk("t4_v0_full_count", 32'(is_empty_o[0]), 32'(0));
    chk("t4_v0_port", 32'(out_port_o[2:0]), 32'(EAST));
    vc_valid_i = 2'b01;
    vc_new_i   = 2'b00;
    exp_dvc[0] = 1'b0;
    tick();
    vc_valid_i = 2'b00;
    for (int i = 0; i < 3; i++) cycle(0, 0, BODY, 16'h0, LOCAL, 2'b01, 0);
    chk("t4_v0_empty", 32'(is_empty_o[0]), 32'(1));
    chk("t4_v0_idle", 32'(sa_request_o[0]), 32'(0));

    // Stray BODY into an idle VC
    do_reset();
    chk("t5_err_clr", 32'(error_o), 32'(0));
    cycle(1, 1, BODY, 16'h5000, LOCAL, 2'b00, 1);
    chk("t5_stored", 32'(is_empty_o[1]), 32'(0));
    tick();
    chk("t5_err", 32'(error_o), 32'(1));
    chk("t5_dropped", 32'(is_empty_o[1]), 32'(1));
    chk("t5_idle", 32'(va_request_o[1]), 32'(0));

    // Reset while VC0 sits in SA with 3 flits buffered
    vc_valid_i = 2'b01;
    vc_new_i   = 2'b01;
    cycle(1, 0, HEAD, 16'h6000, NORTH, 2'b00, 0);
    cycle(1, 0, BODY, 16'h6001, LOCAL, 2'b00, 0);
    cycle(1, 0, BODY, 16'h6002, LOCAL, 2'b00, 0);
    chk("t6_sa", 32'(sa_request_o[0]), 32'(1));
    rst        = 1'b1;
    vc_valid_i = 2'b00;
    tick();
    check_reset("t6_rst");
    rst = 1'b0;
    sb[0].delete();
    sb[1].delete();
    tick();
    check_reset("t6_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
